piso_serializer: RTL

//   Parallel-in/serial-out transmitter that sits directly upstream of sipo.
//   It accepts a WIDTH-bit word through a valid/ready handshake.
//   It shifts the word out one bit per clk on serial_out, which drives sipo.serial_in.

---
 rtl/piso_serializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter feeding a sipo receiver; valid/ready word input, one bit per clk out.
// Optional trailing parity bit when PISO_PARITY_EN is defined (frame grows to WIDTH+1 bits).
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             last_bit
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int              CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_next;
  logic [WIDTH-1:0] r_shift, w_shift_next, w_shift_adv;
  logic             w_data_bit, w_frame_bit;

  // The outgoing data bit always sits at one end of the shift register.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_data_bit  = r_shift[WIDTH-1];
      assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_data_bit  = r_shift[0];
      assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

`ifdef PISO_PARITY_EN
  logic r_parity, w_parity_next;
  assign w_frame_bit = (r_bit_cnt == CNT_W'(WIDTH)) ? r_parity : w_data_bit;
`else
  assign w_frame_bit = w_data_bit;
  // Parity sense only matters in the parity build; this keeps the parameter referenced.
  generate
    if (PARITY_ODD) begin : g_parity_odd_ignored
    end
  endgenerate
`endif

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
`ifdef PISO_PARITY_EN
    w_parity_next  = r_parity;
`endif
    data_ready     = 1'b0;
    busy           = 1'b0;
    last_bit       = 1'b0;
    serial_out     = IDLE_LEVEL;

    case (r_state)
      S_IDLE: begin
        data_ready = 1'b1;
      end
      S_SHIFT: begin
        busy       = 1'b1;
        serial_out = w_frame_bit;
        if (r_bit_cnt == LAST_CNT) begin
          last_bit       = 1'b1;
          data_ready     = 1'b1;
          w_state_next   = S_IDLE;
          w_bit_cnt_next = '0;
        end else begin
          w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
          w_shift_next   = w_shift_adv;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_bit_cnt_next = '0;
      end
    endcase

    // An accept in the last_bit cycle reloads directly, giving gap-free streaming.
    if (data_valid && data_ready) begin
      w_state_next   = S_SHIFT;
      w_bit_cnt_next = '0;
      w_shift_next   = data_in;
`ifdef PISO_PARITY_EN
      w_parity_next  = (^data_in) ^ PARITY_ODD;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
`ifdef PISO_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_shift   <= w_shift_next;
`ifdef PISO_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end
  end

endmodule
